// File: rtl/reg_write_arbiter.sv
// Shares one W-bit register among N requesters using round-robin grant and 4-phase ack.
// Define FIXED_PRIO_EN for fixed priority, where the lowest index wins and ptr stays at 0.
module reg_write_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [N-1:0]   Req,
    input  logic [W*N-1:0] Data,
    output logic [N-1:0]   Gnt,
    output logic [N-1:0]   Ack,
    output logic [W-1:0]   Q,
    output logic           Busy,
    output logic [7:0]     WrCount
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StAck} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [W-1:0]    q_q, q_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic [IW-1:0]   cand_idx;
    logic [W-1:0]    sel_data;

    // Search upward from ptr with wrap; under fixed priority ptr stays 0.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand_idx  = '0;
        for (int k = 0; k < int'(N); k++) begin
            cand_idx = IW'((int'(ptr_q) + k) % int'(N));
            if (!win_found && Req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (idx_q == IW'(k)) begin
                sel_data = Data[k*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    idx_d   = win_idx;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                q_d     = sel_data;
                ack_d   = {{(N-1){1'b0}}, 1'b1} << idx_q;
                cnt_d   = cnt_q + 8'd1;
                state_d = StAck;
            end
            StAck: begin
                if (!Req[idx_q]) begin
                    gnt_d   = '0;
                    ack_d   = '0;
`ifndef FIXED_PRIO_EN
                    ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Gnt     = gnt_q;
    assign Ack     = ack_q;
    assign Q       = q_q;
    assign Busy    = (state_q != StIdle);
    assign WrCount = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: stimulus pushes expected writes, monitor pops on Ack.
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           Clk = 1'b0;
    logic           Rst;
    logic [N-1:0]   Req;
    logic [W*N-1:0] Data;
    logic [N-1:0]   Gnt;
    logic [N-1:0]   Ack;
    logic [W-1:0]   Q;
    logic           Busy;
    logic [7:0]     WrCount;

    reg_write_arbiter #(.N(N), .W(W)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Req     (Req),
        .Data    (Data),
        .Gnt     (Gnt),
        .Ack     (Ack),
        .Q       (Q),
        .Busy    (Busy),
        .WrCount (WrCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         n_err = 0;
    int         n_chk = 0;
    logic [7:0] exp_wr = 8'd0;
    logic [N-1:0] gnt_prev = '0;
    logic [N-1:0] ack_prev = '0;
    exp_t       mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input int i, input logic [7:0] d);
        exp_t e;
        exp_wr = exp_wr + 8'd1;
        e.idx  = i;
        e.data = d;
        e.cnt  = exp_wr;
        exp_q.push_back(e);
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        Data[i*W +: W] = d;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        Req = '0;
        tick();
        tick();
        Rst = 1'b0;
        exp_wr = 8'd0;
        exp_q.delete();
    endtask

    task automatic do_write(input int i, input logic [7:0] d);
        bit got;
        set_data(i, d);
        push(i, d);
        Req[i] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (Ack[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("ack_timeout", 32'(Ack), 32'(1) << i);
        Req[i] = 1'b0;
        tick();
    endtask

    initial begin
        bit got;
        int j;

        fork
            forever begin
                @(negedge Clk);
                if (Rst) begin
                    gnt_prev = '0;
                    ack_prev = '0;
                end else begin
                    if (Gnt != '0 && gnt_prev == '0) begin
                        if (exp_q.size() == 0) chk("unexpected_gnt", 32'(Gnt), 32'd0);
                        else chk("gnt", 32'(Gnt), 32'(1) << exp_q[0].idx);
                    end
                    if (Ack != '0 && ack_prev == '0) begin
                        if (exp_q.size() == 0) chk("unexpected_ack", 32'(Ack), 32'd0);
                        else begin
                            mon_e = exp_q.pop_front();
                            chk("ack", 32'(Ack), 32'(1) << mon_e.idx);
                            chk("q", 32'(Q), 32'(mon_e.data));
                            chk("wrcount", 32'(WrCount), 32'(mon_e.cnt));
                        end
                    end
                    if (Ack != '0) chk("gnt_matches_ack", 32'(Gnt), 32'(Ack));
                    gnt_prev = Gnt;
                    ack_prev = Ack;
                end
            end
        join_none

        // Power-on reset
        Rst  = 1'b1;
        Req  = '0;
        Data = '0;
        tick();
        tick();
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_gnt", 32'(Gnt), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_wrcount", 32'(WrCount), 32'd0);
        Rst = 1'b0;
        tick();

        // Reset asserted mid-cycle while in ACK
        set_data(0, 8'h3C);
        push(0, 8'h3C);
        Req[0] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (Ack[0]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("t1_ack_timeout", 32'(Ack), 32'd1);
        #5;
        Rst = 1'b1;
        #1;
        chk("t1_q", 32'(Q), 32'd0);
        chk("t1_gnt", 32'(Gnt), 32'd0);
        chk("t1_ack", 32'(Ack), 32'd0);
        chk("t1_busy", 32'(Busy), 32'd0);
        chk("t1_wrcount", 32'(WrCount), 32'd0);
        Req = '0;
        tick();
        tick();
        Rst = 1'b0;
        exp_wr = 8'd0;
        exp_q.delete();
        tick();
        tick();
        tick();
        chk("t1_no_spurious_ack", 32'(Ack), 32'd0);
        chk("t1_idle", 32'(Busy), 32'd0);

        // Single write
        do_write(0, 8'hA5);
        chk("t2_gnt_released", 32'(Gnt), 32'd0);
        chk("t2_ack_released", 32'(Ack), 32'd0);
        chk("t2_busy", 32'(Busy), 32'd0);
        chk("t2_q_held", 32'(Q), 32'hA5);

        // Round-robin with all requesters active
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 8'(8'hD0 + i));
`ifdef FIXED_PRIO_EN
        for (int r = 0; r < 5; r++) push(0, 8'hD0);
`else
        push(0, 8'hD0);
        push(1, 8'hD1);
        push(2, 8'hD2);
        push(3, 8'hD3);
        push(0, 8'hD0);
`endif
        Req = '1;
        for (int r = 0; r < 5; r++) begin
            got = 1'b0;
            for (int n = 0; n < 10; n++) begin
                tick();
                if (Ack != '0) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) chk("t3_ack_timeout", 32'(Ack), 32'd1);
            j = 0;
            for (int b = 0; b < N; b++) if (Ack[b]) j = b;
            if (r < 4) begin
                tick();
                Req[j] = 1'b0;
                tick();
                Req[j] = 1'b1;
            end else begin
                Req = '0;
                tick();
            end
        end
        chk("t3_idle", 32'(Busy), 32'd0);

        // Request dropped during LOAD
        set_data(0, 8'h5A);
        push(0, 8'h5A);
        Req[0] = 1'b1;
        tick();
        Req[0] = 1'b0;
        tick();
        chk("t4_ack_pulse", 32'(Ack), 32'd1);
        chk("t4_q", 32'(Q), 32'h5A);
        tick();
        chk("t4_ack_gone", 32'(Ack), 32'd0);
        chk("t4_idle", 32'(Busy), 32'd0);

        // Contention while busy
        set_data(1, 8'h71);
        set_data(2, 8'h82);
        push(1, 8'h71);
        Req = 4'b0010;
        tick();
        tick();
        Req = 4'b0110;
        tick();
        chk("t5_gnt_held", 32'(Gnt), 32'b0010);
        push(2, 8'h82);
        Req = 4'b0100;
        tick();
        chk("t5_gnt_released", 32'(Gnt), 32'd0);
        tick();
        chk("t5_gnt2", 32'(Gnt), 32'b0100);
        tick();
        chk("t5_q2", 32'(Q), 32'h82);
        Req = '0;
        tick();

        // Counter wrap
        do_reset();
        for (int k = 0; k < 256; k++) do_write(k % N, 8'(k) ^ 8'h5A);
        chk("t6_wrcount_wrapped", 32'(WrCount), 32'd0);
        chk("t6_q_last", 32'(Q), 32'hA5);

        tick();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
